// File: rtl/dbus_responder.sv
// Data-cache request responder: queues up to DEPTH load/store requests, issues
// them in order on a grant/valid memory port and returns one data_ok per request.
module dbus_responder #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dcache_req,
  input  logic        dcache_wr,
  input  logic [3:0]  dcache_wstrb,
  input  logic [2:0]  dcache_size,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  output logic        dcache_addr_ok,
  output logic        dcache_data_ok,
  output logic [31:0] dcache_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Handshake: a request transfers on a cycle where dcache_req && dcache_addr_ok;
  // mem_req stays high with stable fields until the cycle mem_gnt is seen.
  typedef enum logic { IDLE, REQ } issue_state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic        q_wr    [DEPTH];
  logic [3:0]  q_wstrb [DEPTH];
  logic [2:0]  q_size  [DEPTH];
  logic [31:0] q_addr  [DEPTH];
  logic [31:0] q_wdata [DEPTH];

  // Pointers carry one wrap bit so a full queue is distinguishable from an empty one.
  logic [PTR_W:0] wptr, iptr, rptr;
  logic [PTR_W:0] count;
  issue_state_t   state;

  logic             accept;
  logic [3:0]       in_wstrb;
  logic [PTR_W:0]   sel_ptr;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             slot_pending;
  logic             nxt_valid;
  logic             nxt_wr;
  logic [3:0]       nxt_wstrb;
  logic [31:0]      nxt_addr;
  logic [31:0]      nxt_wdata;

  assign accept         = dcache_req && (count < FULL);
  assign dcache_addr_ok = accept;
  assign in_wstrb       = dcache_wr ? dcache_wstrb : 4'b0000;
  assign wr_idx         = wptr[PTR_W-1:0];
  assign rd_idx         = rptr[PTR_W-1:0];

  // Next entry to put on the memory port: the oldest unissued slot, or the
  // request being accepted right now when the queue holds nothing unissued.
  always_comb begin
    sel_ptr      = (state == REQ) ? iptr + 1'b1 : iptr;
    sel_idx      = sel_ptr[PTR_W-1:0];
    slot_pending = (sel_ptr != wptr);
    nxt_valid    = slot_pending || accept;
    nxt_wr       = slot_pending ? q_wr[sel_idx]    : dcache_wr;
    nxt_wstrb    = slot_pending ? q_wstrb[sel_idx] : in_wstrb;
    nxt_addr     = slot_pending ? q_addr[sel_idx]  : dcache_addr;
    nxt_wdata    = slot_pending ? q_wdata[sel_idx] : dcache_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr           <= '0;
      iptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_wr         <= 1'b0;
      mem_wstrb      <= 4'b0000;
      mem_addr       <= 32'h0;
      mem_wdata      <= 32'h0;
      dcache_data_ok <= 1'b0;
      dcache_rdata   <= 32'h0;
    end else begin
      if (accept) begin
        q_wr[wr_idx]    <= dcache_wr;
        q_wstrb[wr_idx] <= in_wstrb;
        q_size[wr_idx]  <= dcache_size;
        q_addr[wr_idx]  <= dcache_addr;
        q_wdata[wr_idx] <= dcache_wdata;
        wptr            <= wptr + 1'b1;
      end

      unique case ({accept, dcache_data_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      dcache_data_ok <= mem_rvalid;
      if (mem_rvalid) begin
        dcache_rdata <= q_wr[rd_idx] ? 32'h0 : mem_rdata;
        rptr         <= rptr + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (nxt_valid) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_wr    <= nxt_wr;
            mem_wstrb <= nxt_wstrb;
            mem_addr  <= {nxt_addr[31:2], 2'b00};
            mem_wdata <= nxt_wdata;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            iptr <= iptr + 1'b1;
            if (nxt_valid) begin
              mem_wr    <= nxt_wr;
              mem_wstrb <= nxt_wstrb;
              mem_addr  <= {nxt_addr[31:2], 2'b00};
              mem_wdata <= nxt_wdata;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A completion needs an issued-but-unretired entry; a grant in the same cycle counts.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_rvalid && (iptr == rptr) && !(mem_req && mem_gnt)));
      assert (count <= FULL);
      if (iptr != rptr)
        assert (!((q_size[rd_idx] == 3'd1 && q_addr[rd_idx][0]) ||
                  (q_size[rd_idx] == 3'd2 && q_addr[rd_idx][1:0] != 2'b00)));
    end
  end
`endif

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder with a credit-limited in-order backend model.
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        dcache_req;
  logic        dcache_wr;
  logic [3:0]  dcache_wstrb;
  logic [2:0]  dcache_size;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic        dcache_addr_ok;
  logic        dcache_data_ok;
  logic [31:0] dcache_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int gnt_credit = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        log_wr[$];
  logic [3:0]  log_wstrb[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] be_word;

  dbus_responder #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_wstrb(dcache_wstrb),
    .dcache_size(dcache_size), .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok), .dcache_rdata(dcache_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Backend: grants while credit remains, completes in the grant cycle.
  // Unwritten words read back as their own address.
  always @(posedge clk) begin
    #2;
    if (!reset && mem_req && gnt_credit > 0) begin
      gnt_credit--;
      be_word = mem_model.exists(mem_addr) ? mem_model[mem_addr] : mem_addr;
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = be_word;
      if (mem_wr) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) be_word[8*b +: 8] = mem_wdata[8*b +: 8];
        mem_model[mem_addr] = be_word;
      end
      log_wr.push_back(mem_wr);
      log_wstrb.push_back(mem_wstrb);
      log_addr.push_back(mem_addr);
      log_wdata.push_back(mem_wdata);
    end else begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
  end

  // response monitor
  always @(posedge clk) begin
    #3;
    if (dcache_data_ok) got_q.push_back(dcache_rdata);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic idle();
    dcache_req   = 1'b0;
    dcache_wr    = 1'b0;
    dcache_wstrb = 4'b0000;
    dcache_size  = 3'd2;
    dcache_addr  = 32'h0;
    dcache_wdata = 32'h0;
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    log_wr.delete();
    log_wstrb.delete();
    log_addr.delete();
    log_wdata.delete();
  endtask

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send(input logic wr, input logic [3:0] ws, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, output int stalls);
    dcache_req   = 1'b1;
    dcache_wr    = wr;
    dcache_wstrb = ws;
    dcache_size  = sz;
    dcache_addr  = a;
    dcache_wdata = wd;
    stalls = 0;
    #1;
    while (!dcache_addr_ok && stalls < 50) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    @(negedge clk);
  endtask

  task automatic wait_resp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dcache_data_ok !== 1'b0) begin failures++; $display("FAIL reset_data_ok: got %b want 0", dcache_data_ok); end
    checks++; if (dcache_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", dcache_rdata); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    dcache_req = 1'b1;
    #1;
    checks++; if (dcache_addr_ok !== 1'b1) begin failures++; $display("FAIL reset_addr_ok_empty: got %b want 1", dcache_addr_ok); end
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_release_mem_req: got %b want 0", mem_req); end
    @(negedge clk);
  endtask

  task automatic test_single_load();
    clear_logs();
    gnt_credit = 1000;
    mem_model[32'h1000_0004] = 32'hDEAD_BEEF;
    dcache_req   = 1'b1;
    dcache_wr    = 1'b0;
    dcache_wstrb = 4'b0000;
    dcache_size  = 3'd2;
    dcache_addr  = 32'h1000_0004;
    dcache_wdata = 32'h0;
    #1;
    checks++; if (dcache_addr_ok !== 1'b1) begin failures++; $display("FAIL single_addr_ok_c0: got %b want 1", dcache_addr_ok); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL single_mem_req_c1: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 32'h1000_0004) begin failures++; $display("FAIL single_mem_addr_c1: got %h want 10000004", mem_addr); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL single_mem_wr_c1: got %b want 0", mem_wr); end
    @(negedge clk);
    #1;
    checks++; if (dcache_data_ok !== 1'b1) begin failures++; $display("FAIL single_data_ok_c2: got %b want 1", dcache_data_ok); end
    checks++; if (dcache_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata_c2: got %h want deadbeef", dcache_rdata); end
    @(negedge clk);
    #1;
    checks++; if (dcache_data_ok !== 1'b0) begin failures++; $display("FAIL single_data_ok_c3: got %b want 0", dcache_data_ok); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL single_mem_req_c3: got %b want 0", mem_req); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_resp_count: got %0d want 1", got_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int st;
    bit ok;
    clear_logs();
    gnt_credit = 1000;
    send(1'b1, 4'b0011, 3'd2, 32'h0000_2000, 32'h1234_5678, st);
    send(1'b0, 4'b1111, 3'd2, 32'h0000_2000, 32'hFFFF_FFFF, st);
    idle();
    wait_resp(2, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL stld_timeout: got %0d responses want 2", got_q.size()); end
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL stld_resp_count: got %0d want 2", got_q.size()); end
    checks++; if (log_addr.size() != 2) begin failures++; $display("FAIL stld_mem_count: got %0d want 2", log_addr.size()); end
    if (got_q.size() == 2 && log_addr.size() == 2) begin
      checks++; if (log_wr[0] !== 1'b1) begin failures++; $display("FAIL stld_first_is_write: got %b want 1", log_wr[0]); end
      checks++; if (log_wstrb[0] !== 4'b0011) begin failures++; $display("FAIL stld_store_wstrb: got %b want 0011", log_wstrb[0]); end
      checks++; if (log_wdata[0] !== 32'h1234_5678) begin failures++; $display("FAIL stld_store_wdata: got %h want 12345678", log_wdata[0]); end
      checks++; if (log_wr[1] !== 1'b0) begin failures++; $display("FAIL stld_second_is_read: got %b want 0", log_wr[1]); end
      checks++; if (log_wstrb[1] !== 4'b0000) begin failures++; $display("FAIL stld_load_wstrb: got %b want 0000", log_wstrb[1]); end
      checks++; if (got_q[0] !== 32'h0) begin failures++; $display("FAIL stld_store_rdata: got %h want 0", got_q[0]); end
      checks++; if (got_q[1] !== 32'h0000_5678) begin failures++; $display("FAIL stld_load_rdata: got %h want 00005678", got_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    int unstable;
    bit ok;
    clear_logs();
    gnt_credit = 0;
    pulses = 0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      dcache_req   = 1'b1;
      dcache_wr    = 1'b0;
      dcache_wstrb = 4'b0000;
      dcache_size  = 3'd2;
      dcache_addr  = 32'h0000_3000 + 32'(4 * i);
      dcache_wdata = 32'h0;
      #1;
      if (dcache_addr_ok) pulses++;
      if (i >= 1 && (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000 || mem_wr !== 1'b0 || mem_wstrb !== 4'b0000))
        unstable++;
      @(negedge clk);
    end
    checks++; if (pulses != 4) begin failures++; $display("FAIL bp_addr_ok_pulses: got %0d want 4", pulses); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL bp_mem_stable: got %0d unstable cycles want 0", unstable); end
    idle();
    gnt_credit = 1000;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_3000 + 32'(4 * i));
    wait_resp(4, ok);
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL bp_resp_count: got %0d want 4", got_q.size()); end
    if (got_q.size() == 4 && log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_rdata[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        checks++; if (log_addr[i] !== exp_q[i]) begin failures++; $display("FAIL bp_mem_addr[%0d]: got %h want %h", i, log_addr[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_simultaneous();
    int st;
    int dok_k;
    int dok_cnt;
    int aok_k;
    int aok_cnt;
    bit ok;
    clear_logs();
    gnt_credit = 0;
    for (int i = 0; i < 4; i++) send(1'b0, 4'b0000, 3'd2, 32'h0000_4000 + 32'(4 * i), 32'h0, st);
    dcache_req   = 1'b1;
    dcache_wr    = 1'b0;
    dcache_wstrb = 4'b0000;
    dcache_size  = 3'd2;
    dcache_addr  = 32'h0000_5000;
    dcache_wdata = 32'h0;
    #1;
    checks++; if (dcache_addr_ok !== 1'b0) begin failures++; $display("FAIL sim_full_addr_ok: got %b want 0", dcache_addr_ok); end
    gnt_credit = 1;
    dok_k = -1; aok_k = -1; dok_cnt = 0; aok_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (dcache_data_ok) begin dok_cnt++; dok_k = k; end
      if (dcache_addr_ok) begin aok_cnt++; aok_k = k; end
    end
    checks++; if (dok_cnt != 1) begin failures++; $display("FAIL sim_data_ok_count: got %0d want 1", dok_cnt); end
    checks++; if (aok_cnt != 1) begin failures++; $display("FAIL sim_addr_ok_count: got %0d want 1", aok_cnt); end
    checks++; if (aok_k != dok_k + 1) begin failures++; $display("FAIL sim_addr_ok_cycle: got %0d want %0d", aok_k, dok_k + 1); end
    idle();
    gnt_credit = 1000;
    exp_q = '{32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h5000};
    wait_resp(5, ok);
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL sim_resp_count: got %0d want 5", got_q.size()); end
    if (got_q.size() == 5)
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL sim_rdata[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
  endtask

  task automatic test_wrap();
    int st;
    int total_stalls;
    bit ok;
    clear_logs();
    gnt_credit = 1000;
    total_stalls = 0;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(32'(4 * i));
      send(1'b0, 4'b0000, 3'd2, 32'(4 * i), 32'h0, st);
      total_stalls += st;
    end
    idle();
    wait_resp(11, ok);
    repeat (3) @(negedge clk);
    checks++; if (total_stalls != 0) begin failures++; $display("FAIL wrap_stalls: got %0d want 0", total_stalls); end
    checks++; if (got_q.size() != 11) begin failures++; $display("FAIL wrap_resp_count: got %0d want 11", got_q.size()); end
    if (got_q.size() == 11)
      for (int i = 0; i < 11; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_rdata[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
  endtask

  task automatic test_reset_mid();
    int st;
    int pulses;
    bit ok;
    clear_logs();
    gnt_credit = 0;
    for (int i = 0; i < 3; i++) send(1'b0, 4'b0000, 3'd2, 32'h0000_6000 + 32'(4 * i), 32'h0, st);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rmid_mem_req: got %b want 0", mem_req); end
    checks++; if (dcache_data_ok !== 1'b0) begin failures++; $display("FAIL rmid_data_ok: got %b want 0", dcache_data_ok); end
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      dcache_req  = 1'b1;
      dcache_addr = 32'h0000_7000 + 32'(4 * i);
      #1;
      if (dcache_addr_ok) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 4) begin failures++; $display("FAIL rmid_free_slots: got %0d want 4", pulses); end
    idle();
    gnt_credit = 1000;
    exp_q = '{32'h7000, 32'h7004, 32'h7008, 32'h700C};
    wait_resp(4, ok);
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL rmid_resp_count: got %0d want 4", got_q.size()); end
    checks++; if (log_addr.size() != 4) begin failures++; $display("FAIL rmid_mem_count: got %0d want 4", log_addr.size()); end
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_rdata[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
  endtask

  initial begin
    reset      = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    idle();
    test_reset();
    test_single_load();
    test_store_load();
    test_backpressure();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
